// File: rtl/neogeo_video_out_timing.sv
`timescale 1ns/1ps
// neogeo_video_out_timing
//
// Output timing stage that sits right after the LSPC sync generator. The raw
// sync signals are delayed so they line up with the pixel data pipeline. They
// are then turned into clean blanking, data-enable and sync outputs, with an
// optional 304-pixel narrow crop and active-area X/Y counters.
//
// Parameters
//   PIPE_DLY    pixel-enable delay applied to the sync inputs (0..15)
//   H_CROP      pixels blanked at each side of the active line in narrow mode
//   H_ACTIVE    nominal active pixels per line
//
// Ports
//   CLK          in   system clock
//   RESETP       in   asynchronous active-high reset
//   PIX_CE       in   one-CLK pixel enable (6 MHz); all timing state advances on it
//   NARROW       in   1 = crop line to H_ACTIVE-2*H_CROP pixels, taken at line start
//   HSYNC        in   horizontal sync from sync generator, active-low
//   VSYNC        in   vertical sync from sync generator, active-high
//   BNK          in   low during vertical blank
//   CHBL         in   high during horizontal blank
//   CE_PIX       out  PIX_CE delayed by one CLK
//   HS           out  horizontal sync, active-high
//   VS           out  vertical sync, active-high, changes only when HS rises
//   HBLANK       out  horizontal blank including the crop region
//   VBLANK       out  vertical blank, changes only when HBLANK rises
//   DE           out  data enable, ~HBLANK & ~VBLANK
//   ACT_X        out  active pixel index within the line
//   ACT_Y        out  active line index within the frame
//   FRAME_START  out  one-CLK pulse on the first DE pixel of a frame
module neogeo_video_out_timing #(
    parameter int PIPE_DLY = 4,
    parameter int H_CROP   = 8,
    parameter int H_ACTIVE = 320
) (
    input  logic       CLK,
    input  logic       RESETP,
    input  logic       PIX_CE,
    input  logic       NARROW,
    input  logic       HSYNC,
    input  logic       VSYNC,
    input  logic       BNK,
    input  logic       CHBL,
    output logic       CE_PIX,
    output logic       HS,
    output logic       VS,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic       DE,
    output logic [8:0] ACT_X,
    output logic [8:0] ACT_Y,
    output logic       FRAME_START
);

    localparam logic [8:0] CROP_LO = 9'(H_CROP);
    localparam logic [8:0] CROP_HI = 9'(H_ACTIVE - H_CROP);
    localparam logic [8:0] CNT_MAX = 9'h1FF;

    // Bit order of a delay-line word: {HSYNC, VSYNC, BNK, CHBL}.
    localparam logic [3:0] SYNC_IDLE = 4'b1001;

    logic [3:0] sync_in;
    logic [3:0] sync_d;
    logic       hsync_d;
    logic       vsync_d;
    logic       bnk_d;
    logic       chbl_d;

    logic       chbl_q;
    logic [8:0] hcnt;
    logic       narrow_l;
    logic       line_de;
    logic       frame_armed;

    logic       chbl_fall;
    logic       chbl_rise;
    logic [8:0] hcnt_next;
    logic       crop;
    logic       hblank_next;
    logic       hblank_rise;
    logic       hs_next;
    logic       hs_rise;
    logic       vblank_next;
    logic       de_next;
    logic [8:0] act_x_next;
    logic [8:0] act_y_next;
    logic       line_de_next;
    logic       armed_next;

    assign sync_in = {HSYNC, VSYNC, BNK, CHBL};

    // The delay line resets to idle sync levels. This way a reset in the
    // middle of a line looks like blanking rather than a stale partial line.
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign sync_d = sync_in;
        end else begin : g_dly
            logic [3:0] stage [PIPE_DLY];

            always_ff @(posedge CLK or posedge RESETP) begin
                if (RESETP) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        stage[i] <= SYNC_IDLE;
                    end
                end else if (PIX_CE) begin
                    stage[0] <= sync_in;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign sync_d = stage[PIPE_DLY-1];
        end
    endgenerate

    assign {hsync_d, vsync_d, bnk_d, chbl_d} = sync_d;

    assign DE = ~HBLANK & ~VBLANK;

    // Next-state values for the enable-gated timing registers. Every edge
    // (HS rise, HBLANK rise, CHBL_d edges) is judged on the value about to be
    // loaded, so the edge and its side effects land on the same enable.
    always_comb begin
        chbl_fall = chbl_q & ~chbl_d;
        chbl_rise = ~chbl_q & chbl_d;

        hcnt_next = hcnt;
        if (chbl_fall) begin
            hcnt_next = '0;
        end else if (!chbl_d && hcnt != CNT_MAX) begin
            hcnt_next = hcnt + 9'd1;
        end

        crop        = narrow_l & ((hcnt_next < CROP_LO) | (hcnt_next >= CROP_HI));
        hblank_next = chbl_d | crop;
        hblank_rise = hblank_next & ~HBLANK;

        hs_next = ~hsync_d;
        hs_rise = hs_next & ~HS;

        // VBLANK only moves at the end of a line, so a BNK edge can never
        // split a line.
        vblank_next = hblank_rise ? ~bnk_d : VBLANK;
        de_next     = ~hblank_next & ~vblank_next;

        act_x_next = ACT_X;
        if (hblank_rise) begin
            act_x_next = '0;
        end else if (DE && ACT_X != CNT_MAX) begin
            act_x_next = ACT_X + 9'd1;
        end

        // The current DE is ORed in because the last visible pixel is still
        // being shown on the enable where HBLANK rises.
        act_y_next = ACT_Y;
        if (vblank_next) begin
            act_y_next = '0;
        end else if (hblank_rise && (line_de || DE) && ACT_Y != CNT_MAX) begin
            act_y_next = ACT_Y + 9'd1;
        end

        line_de_next = line_de;
        if (hblank_rise) begin
            line_de_next = 1'b0;
        end else if (DE) begin
            line_de_next = 1'b1;
        end

        armed_next = frame_armed;
        if (de_next) begin
            armed_next = 1'b0;
        end else if (vblank_next) begin
            armed_next = 1'b1;
        end
    end

    // Pixel-rate timing registers. They hold whenever PIX_CE is low. VS
    // samples the delayed VSYNC of the very enable on which HS rises.
    always_ff @(posedge CLK or posedge RESETP) begin
        if (RESETP) begin
            HS          <= 1'b0;
            VS          <= 1'b0;
            HBLANK      <= 1'b1;
            VBLANK      <= 1'b1;
            ACT_X       <= '0;
            ACT_Y       <= '0;
            chbl_q      <= 1'b1;
            hcnt        <= '0;
            narrow_l    <= 1'b0;
            line_de     <= 1'b0;
            frame_armed <= 1'b1;
        end else if (PIX_CE) begin
            HS <= hs_next;
            if (hs_rise) begin
                VS <= vsync_d;
            end
            chbl_q <= chbl_d;
            hcnt   <= hcnt_next;
            if (chbl_rise) begin
                narrow_l <= NARROW;
            end
            HBLANK      <= hblank_next;
            VBLANK      <= vblank_next;
            ACT_X       <= act_x_next;
            ACT_Y       <= act_y_next;
            line_de     <= line_de_next;
            frame_armed <= armed_next;
        end
    end

    // CLK-rate registers. FRAME_START is qualified by PIX_CE, so it clears
    // on the CLK after the enable that raised it.
    always_ff @(posedge CLK or posedge RESETP) begin
        if (RESETP) begin
            CE_PIX      <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            CE_PIX      <= PIX_CE;
            FRAME_START <= PIX_CE & de_next & frame_armed;
        end
    end

endmodule

// File: tb/tb_neogeo_video_out_timing.sv
`timescale 1ns/1ps
// tb_neogeo_video_out_timing
//
// Directed testbench for neogeo_video_out_timing. Lines are 384 pixels long:
// CHBL is low for pixels 0..319 and HSYNC is low for pixels 336..367. There
// is one PIX_CE every 4 CLK. Each pixel is sampled 1 ns after its enable edge,
// and per-line statistics are collected. The test tasks compare these
// statistics against hand-computed values.
module tb_neogeo_video_out_timing;

    logic       CLK = 1'b0;
    logic       RESETP = 1'b1;
    logic       PIX_CE = 1'b0;
    logic       NARROW = 1'b0;
    logic       HSYNC = 1'b1;
    logic       VSYNC = 1'b0;
    logic       BNK = 1'b0;
    logic       CHBL = 1'b1;
    logic       CE_PIX;
    logic       HS;
    logic       VS;
    logic       HBLANK;
    logic       VBLANK;
    logic       DE;
    logic [8:0] ACT_X;
    logic [8:0] ACT_Y;
    logic       FRAME_START;

    int errors = 0;
    int checks = 0;
    int exp_y  = 0;

    int         cur_p = -1;
    int         de_cnt, first_de_p, last_de_p, x_bad;
    int         hs_rise_p, vs_chg_p, hb_fall_p, hb_rise_p, vb_chg_p, fs_cnt;
    logic [8:0] last_x, line_y, fs_x, fs_y;
    logic       hs_prev = 1'b0;
    logic       vs_prev = 1'b0;
    logic       hb_prev = 1'b1;
    logic       vb_prev = 1'b1;

    int         de_at_rst;
    logic [8:0] pre_x, pre_y, rst_x, rst_y;
    logic       rst_de, rst_hb, rst_vb;

    neogeo_video_out_timing dut (
        .CLK         (CLK),
        .RESETP      (RESETP),
        .PIX_CE      (PIX_CE),
        .NARROW      (NARROW),
        .HSYNC       (HSYNC),
        .VSYNC       (VSYNC),
        .BNK         (BNK),
        .CHBL        (CHBL),
        .CE_PIX      (CE_PIX),
        .HS          (HS),
        .VS          (VS),
        .HBLANK      (HBLANK),
        .VBLANK      (VBLANK),
        .DE          (DE),
        .ACT_X       (ACT_X),
        .ACT_Y       (ACT_Y),
        .FRAME_START (FRAME_START)
    );

    always #5 CLK = ~CLK;

    task automatic clear_stats();
        de_cnt = 0; first_de_p = -1; last_de_p = -1; x_bad = 0;
        hs_rise_p = -1; vs_chg_p = -1; hb_fall_p = -1; hb_rise_p = -1;
        vb_chg_p = -1; fs_cnt = 0;
        last_x = '0; line_y = '0; fs_x = '1; fs_y = '1;
    endtask

    // Record what the DUT shows after one pixel enable.
    task automatic sample();
        if (DE) begin
            if (de_cnt == 0) first_de_p = cur_p;
            if (ACT_X !== 9'(de_cnt)) x_bad++;
            last_de_p = cur_p;
            last_x    = ACT_X;
            line_y    = ACT_Y;
            de_cnt++;
        end
        if (HS && !hs_prev) hs_rise_p = cur_p;
        if (VS !== vs_prev) vs_chg_p = cur_p;
        if (!HBLANK && hb_prev) hb_fall_p = cur_p;
        if (HBLANK && !hb_prev) hb_rise_p = cur_p;
        if (VBLANK !== vb_prev) vb_chg_p = cur_p;
        hs_prev = HS; vs_prev = VS; hb_prev = HBLANK; vb_prev = VBLANK;
        if (FRAME_START) begin
            fs_cnt++;
            fs_x = ACT_X;
            fs_y = ACT_Y;
        end
    endtask

    // One pixel: inputs and PIX_CE for one CLK, then three idle CLKs.
    task automatic pix(input logic h, input logic v, input logic b, input logic c);
        HSYNC = h; VSYNC = v; BNK = b; CHBL = c; PIX_CE = 1'b1;
        @(posedge CLK); #1;
        PIX_CE = 1'b0;
        sample();
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            if (FRAME_START) fs_cnt++;
        end
    endtask

    // One full line. BNK, VSYNC and NARROW switch from their _a value to
    // their _b value at pixel chg_px. An optional 1-CLK reset is applied
    // right after pixel rst_px.
    task automatic run_line(input logic bnk_a, input logic bnk_b,
                            input logic vs_a, input logic vs_b,
                            input logic nar_a, input logic nar_b,
                            input int chg_px, input int rst_px);
        clear_stats();
        for (int p = 0; p < 384; p++) begin
            cur_p  = p;
            NARROW = (p < chg_px) ? nar_a : nar_b;
            pix(!(p >= 336 && p < 368), (p < chg_px) ? vs_a : vs_b,
                (p < chg_px) ? bnk_a : bnk_b, p >= 320);
            if (p == rst_px) begin
                pre_x = ACT_X; pre_y = ACT_Y; de_at_rst = de_cnt;
                RESETP = 1'b1;
                #1;
                rst_de = DE; rst_hb = HBLANK; rst_vb = VBLANK;
                rst_x = ACT_X; rst_y = ACT_Y;
                @(posedge CLK); #1;
                RESETP = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (HS !== 1'b0) begin errors++; $display("[TB] FAIL reset_hs: got %0d expected 0", HS); end
        checks++; if (VS !== 1'b0) begin errors++; $display("[TB] FAIL reset_vs: got %0d expected 0", VS); end
        checks++; if (HBLANK !== 1'b1) begin errors++; $display("[TB] FAIL reset_hblank: got %0d expected 1", HBLANK); end
        checks++; if (VBLANK !== 1'b1) begin errors++; $display("[TB] FAIL reset_vblank: got %0d expected 1", VBLANK); end
        checks++; if (DE !== 1'b0) begin errors++; $display("[TB] FAIL reset_de: got %0d expected 0", DE); end
        checks++; if (ACT_X !== 9'd0 || ACT_Y !== 9'd0) begin errors++; $display("[TB] FAIL reset_act: got x=%0d y=%0d expected 0 0", ACT_X, ACT_Y); end
        checks++; if (FRAME_START !== 1'b0 || CE_PIX !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got fs=%0d ce=%0d expected 0 0", FRAME_START, CE_PIX); end
        RESETP = 1'b0;
        @(posedge CLK); #1;
        PIX_CE = 1'b1;
        @(posedge CLK); #1;
        PIX_CE = 1'b0;
        checks++; if (CE_PIX !== 1'b1) begin errors++; $display("[TB] FAIL ce_pix_high: got %0d expected 1", CE_PIX); end
        @(posedge CLK); #1;
        checks++; if (CE_PIX !== 1'b0) begin errors++; $display("[TB] FAIL ce_pix_low: got %0d expected 0", CE_PIX); end
        for (int i = 0; i < 8; i++) pix(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (HBLANK !== 1'b1 || HS !== 1'b0 || DE !== 1'b0) begin errors++; $display("[TB] FAIL idle_outputs: got hb=%0d hs=%0d de=%0d expected 1 0 0", HBLANK, HS, DE); end
    endtask

    task automatic test_latency();
        run_line(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        checks++; if (hb_fall_p !== 4) begin errors++; $display("[TB] FAIL lat_hblank_fall: got %0d expected 4", hb_fall_p); end
        checks++; if (hb_rise_p !== 324) begin errors++; $display("[TB] FAIL lat_hblank_rise: got %0d expected 324", hb_rise_p); end
        checks++; if (hs_rise_p !== 340) begin errors++; $display("[TB] FAIL lat_hs_rise: got %0d expected 340", hs_rise_p); end
        checks++; if (de_cnt !== 0) begin errors++; $display("[TB] FAIL lat_de_in_vblank: got %0d expected 0", de_cnt); end
        checks++; if (vb_chg_p !== -1 || VBLANK !== 1'b1) begin errors++; $display("[TB] FAIL lat_vblank_hold: got chg=%0d vb=%0d expected -1 1", vb_chg_p, VBLANK); end
    endtask

    task automatic test_vblank_start();
        run_line(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 200, -1);
        checks++; if (vb_chg_p !== 324 || VBLANK !== 1'b0) begin errors++; $display("[TB] FAIL vb_fall_pos: got chg=%0d vb=%0d expected 324 0", vb_chg_p, VBLANK); end
        checks++; if (de_cnt !== 0) begin errors++; $display("[TB] FAIL vb_start_de: got %0d expected 0", de_cnt); end
        run_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        checks++; if (fs_cnt !== 1) begin errors++; $display("[TB] FAIL fs_count: got %0d expected 1", fs_cnt); end
        checks++; if (fs_x !== 9'd0 || fs_y !== 9'd0) begin errors++; $display("[TB] FAIL fs_pos: got x=%0d y=%0d expected 0 0", fs_x, fs_y); end
        checks++; if (de_cnt !== 320) begin errors++; $display("[TB] FAIL first_line_de: got %0d expected 320", de_cnt); end
        checks++; if (first_de_p !== 4 || last_de_p !== 323) begin errors++; $display("[TB] FAIL first_line_span: got %0d..%0d expected 4..323", first_de_p, last_de_p); end
        checks++; if (last_x !== 9'd319 || x_bad !== 0) begin errors++; $display("[TB] FAIL first_line_actx: got last=%0d bad=%0d expected 319 0", last_x, x_bad); end
        checks++; if (line_y !== 9'd0) begin errors++; $display("[TB] FAIL first_line_acty: got %0d expected 0", line_y); end
        exp_y = 1;
    endtask

    task automatic test_full_lines();
        for (int l = 0; l < 2; l++) begin
            run_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
            checks++; if (de_cnt !== 320 || x_bad !== 0) begin errors++; $display("[TB] FAIL full_line_de: got de=%0d bad=%0d expected 320 0", de_cnt, x_bad); end
            checks++; if (line_y !== 9'(exp_y)) begin errors++; $display("[TB] FAIL full_line_acty: got %0d expected %0d", line_y, exp_y); end
            checks++; if (fs_cnt !== 0) begin errors++; $display("[TB] FAIL full_line_fs: got %0d expected 0", fs_cnt); end
            exp_y++;
        end
    endtask

    task automatic test_narrow();
        run_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 100, -1);
        checks++; if (de_cnt !== 320) begin errors++; $display("[TB] FAIL narrow_midline_on: got %0d expected 320", de_cnt); end
        exp_y++;
        run_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, -1);
        checks++; if (de_cnt !== 304) begin errors++; $display("[TB] FAIL narrow_de: got %0d expected 304", de_cnt); end
        checks++; if (first_de_p !== 12 || last_de_p !== 315) begin errors++; $display("[TB] FAIL narrow_span: got %0d..%0d expected 12..315", first_de_p, last_de_p); end
        checks++; if (last_x !== 9'd303 || x_bad !== 0) begin errors++; $display("[TB] FAIL narrow_actx: got last=%0d bad=%0d expected 303 0", last_x, x_bad); end
        checks++; if (hb_rise_p !== 316) begin errors++; $display("[TB] FAIL narrow_hblank_rise: got %0d expected 316", hb_rise_p); end
        checks++; if (line_y !== 9'(exp_y)) begin errors++; $display("[TB] FAIL narrow_acty: got %0d expected %0d", line_y, exp_y); end
        exp_y++;
        run_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 100, -1);
        checks++; if (de_cnt !== 304) begin errors++; $display("[TB] FAIL narrow_midline_off: got %0d expected 304", de_cnt); end
        exp_y++;
    endtask

    task automatic test_vsync();
        run_line(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 150, -1);
        checks++; if (vs_chg_p !== 340 || hs_rise_p !== 340) begin errors++; $display("[TB] FAIL vs_rise_on_hs: got vs=%0d hs=%0d expected 340 340", vs_chg_p, hs_rise_p); end
        checks++; if (VS !== 1'b1 || de_cnt !== 320) begin errors++; $display("[TB] FAIL vs_level: got vs=%0d de=%0d expected 1 320", VS, de_cnt); end
        exp_y++;
        run_line(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 336, -1);
        checks++; if (vs_chg_p !== 340 || VS !== 1'b0) begin errors++; $display("[TB] FAIL vs_same_enable: got chg=%0d vs=%0d expected 340 0", vs_chg_p, VS); end
        exp_y++;
    endtask

    task automatic test_frame_end();
        run_line(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 200, -1);
        checks++; if (line_y !== 9'd8 || de_cnt !== 320) begin errors++; $display("[TB] FAIL last_line: got y=%0d de=%0d expected 8 320", line_y, de_cnt); end
        checks++; if (vb_chg_p !== 324 || VBLANK !== 1'b1 || ACT_Y !== 9'd0) begin errors++; $display("[TB] FAIL vb_rise: got chg=%0d vb=%0d y=%0d expected 324 1 0", vb_chg_p, VBLANK, ACT_Y); end
        run_line(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        checks++; if (de_cnt !== 0 || fs_cnt !== 0) begin errors++; $display("[TB] FAIL vblank_line: got de=%0d fs=%0d expected 0 0", de_cnt, fs_cnt); end
    endtask

    task automatic test_reset_midline();
        run_line(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 200, -1);
        run_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        checks++; if (fs_cnt !== 1 || line_y !== 9'd0) begin errors++; $display("[TB] FAIL frame2_start: got fs=%0d y=%0d expected 1 0", fs_cnt, line_y); end
        run_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 160);
        checks++; if (pre_x !== 9'd156 || pre_y !== 9'd1) begin errors++; $display("[TB] FAIL pre_reset_pos: got x=%0d y=%0d expected 156 1", pre_x, pre_y); end
        checks++; if (rst_de !== 1'b0 || rst_hb !== 1'b1 || rst_vb !== 1'b1) begin errors++; $display("[TB] FAIL reset_blank_now: got de=%0d hb=%0d vb=%0d expected 0 1 1", rst_de, rst_hb, rst_vb); end
        checks++; if (rst_x !== 9'd0 || rst_y !== 9'd0) begin errors++; $display("[TB] FAIL reset_act_clear: got x=%0d y=%0d expected 0 0", rst_x, rst_y); end
        checks++; if (de_at_rst !== 157 || de_cnt !== 157) begin errors++; $display("[TB] FAIL reset_rest_of_line: got %0d/%0d expected 157/157", de_at_rst, de_cnt); end
        run_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        checks++; if (de_cnt !== 320 || first_de_p !== 4) begin errors++; $display("[TB] FAIL post_reset_line: got de=%0d first=%0d expected 320 4", de_cnt, first_de_p); end
        checks++; if (fs_cnt !== 1 || fs_x !== 9'd0 || fs_y !== 9'd0) begin errors++; $display("[TB] FAIL post_reset_fs: got n=%0d x=%0d y=%0d expected 1 0 0", fs_cnt, fs_x, fs_y); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vblank_start();
        test_full_lines();
        test_narrow();
        test_vsync();
        test_frame_end();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
